// File: rtl/led_mode_ctrl.sv
// Switch/LED controller: debounces four switches into press events and sequences
// LED1-LED4 through OFF/BLINK/CHASE/COUNT patterns at a selectable rate.
module led_mode_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned TICK_CYCLES     = 1200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  output logic       LED1,
  output logic       LED2,
  output logic       LED3,
  output logic       LED4,
  output logic       LED5,
  output logic [1:0] mode
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TICK_W = $clog2(TICK_CYCLES);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_COUNT = 2'd3
  } mode_e;

  logic [3:0] sw_raw;
  logic [3:0] press;

  assign sw_raw = {SW4, SW3, SW2, SW1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_db
      logic            sync1_q;
      logic            sync2_q;
      logic            stable_q;
      logic            stable_d;
      logic            stable_dly_q;
      logic [DB_W-1:0] cnt_q;
      logic [DB_W-1:0] cnt_d;

      // The stable level flips on the cycle after the mismatch count has reached the limit.
      always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
          if (cnt_q == DB_W'(DEBOUNCE_CYCLES)) begin
            stable_d = ~stable_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          stable_q     <= 1'b0;
          stable_dly_q <= 1'b0;
          cnt_q        <= '0;
        end else begin
          sync1_q      <= sw_raw[gi];
          sync2_q      <= sync1_q;
          stable_q     <= stable_d;
          stable_dly_q <= stable_q;
          cnt_q        <= cnt_d;
        end
      end

      assign press[gi] = stable_q & ~stable_dly_q;
    end
  endgenerate

  function automatic logic [3:0] init_pat(input mode_e m);
    return (m == MODE_CHASE) ? 4'b0001 : 4'b0000;
  endfunction

  function automatic logic [3:0] step_pat(input mode_e m, input logic [3:0] p);
    logic [3:0] r;
    r = p;
    case (m)
      MODE_BLINK: r = ~p;
      MODE_CHASE: r = {p[2:0], p[3]};
      MODE_COUNT: r = p + 4'd1;
      default:    r = p;
    endcase
    return r;
  endfunction

  mode_e             mode_q,     mode_d;
  logic [1:0]        speed_q,    speed_d;
  logic              paused_q,   paused_d;
  logic [3:0]        pat_q,      pat_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0] period_m1;
  logic              run;
  logic              tick;
  logic              reload;

  assign period_m1 = TICK_W'((TICK_CYCLES >> speed_q) - 1);
  assign run       = !paused_q && (mode_q != MODE_OFF);
  assign tick      = run && (tick_cnt_q == period_m1);
  assign reload    = press[0] | press[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      speed_q    <= 2'd0;
      paused_q   <= 1'b0;
      pat_q      <= 4'b0000;
      tick_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      speed_q    <= speed_d;
      paused_q   <= paused_d;
      pat_q      <= pat_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Later assignments take priority: a reload overrides a coincident tick step.
  always_comb begin
    mode_d     = mode_q;
    speed_d    = speed_q;
    paused_d   = paused_q;
    pat_d      = pat_q;
    tick_cnt_d = tick_cnt_q;

    if (run) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end
    if (mode_q == MODE_OFF || reload || press[1]) begin
      tick_cnt_d = '0;
    end

    if (tick) begin
      pat_d = step_pat(mode_q, pat_q);
    end
    if (press[3]) begin
      pat_d = init_pat(mode_q);
    end
    if (press[0]) begin
      mode_d = mode_e'(mode_q + 2'd1);
      pat_d  = init_pat(mode_d);
    end
    if (press[1]) begin
      speed_d = speed_q + 2'd1;
    end
    if (press[2]) begin
      paused_d = ~paused_q;
    end
  end

  assign LED1 = pat_q[0];
  assign LED2 = pat_q[1];
  assign LED3 = pat_q[2];
  assign LED4 = pat_q[3];
  assign LED5 = paused_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl: every expected change of {mode, LED5, LED4..LED1}
// is queued with the cycle it must appear on; a negedge monitor checks each change.
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       LED1, LED2, LED3, LED4, LED5;
  logic [1:0] mode;

  led_mode_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SW1  (sw[0]),
    .SW2  (sw[1]),
    .SW3  (sw[2]),
    .SW4  (sw[3]),
    .LED1 (LED1),
    .LED2 (LED2),
    .LED3 (LED3),
    .LED4 (LED4),
    .LED5 (LED5),
    .mode (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] val;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [6:0] last_obs = '0;
  logic [3:0] chase_exp [6] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] obs_now();
    return {mode, LED5, LED4, LED3, LED2, LED1};
  endfunction

  task automatic push(input logic [1:0] m, input logic p, input logic [3:0] pt, input int c);
    exp_t e;
    e.val = {m, p, pt};
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] %s ok: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold);
    sw = sw | m;
    repeat (hold) @(negedge clk);
    sw = sw & ~m;
  endtask

  // Monitor: each visible output change must match the head of the queue, value and cycle.
  always @(negedge clk) begin
    logic [6:0] o;
    exp_t       e;
    o = obs_now();
    if (mon_en && o !== last_obs) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got %b at cycle %0d, expected no change", o, cyc);
      end else begin
        e = exp_q.pop_front();
        if (o !== e.val || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL output_change: got %b at cycle %0d, expected %b at cycle %0d",
                   o, cyc, e.val, e.cyc);
        end else begin
          $display("[TB] change ok: %b at cycle %0d", o, cyc);
        end
      end
    end
    last_obs = o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, r1, r2, r3, s, u;
    rst_n = 1'b0;
    sw    = 4'b0000;
    repeat (3) @(negedge clk);
    check("reset_state", int'(obs_now()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Short glitch on SW1: must be rejected.
    c = cyc + 2;
    wait_until(c);
    press(4'b0001, 3);
    repeat (16) @(negedge clk);
    check("glitch_mode", int'(mode), 0);

    // Long SW1 press: BLINK 7 edges after first sample, then two blink steps.
    c = cyc + 2;
    wait_until(c);
    r1 = c + 8;
    push(2'd1, 1'b0, 4'h0, r1);
    push(2'd1, 1'b0, 4'hF, r1 + 16);
    push(2'd1, 1'b0, 4'h0, r1 + 32);
    press(4'b0001, 12);

    // SW1 -> CHASE, six steps at speed 0.
    c = r1 + 34;
    wait_until(c);
    r2 = c + 8;
    push(2'd2, 1'b0, 4'h1, r2);
    for (int k = 0; k < 6; k++) push(2'd2, 1'b0, chase_exp[k], r2 + 16 * (k + 1));
    press(4'b0001, 6);

    // CHASE at 0100: SW1+SW4 together -> COUNT from 0000, first step 16 cycles later.
    c = r2 + 98;
    wait_until(c);
    r3 = c + 8;
    push(2'd3, 1'b0, 4'h0, r3);
    for (int k = 1; k <= 4; k++) push(2'd3, 1'b0, 4'(k), r3 + 16 * k);
    press(4'b1001, 6);

    // SW2 -> speed 1: one step per 8 cycles.
    c = r3 + 66;
    wait_until(c);
    s = c + 8;
    push(2'd3, 1'b0, 4'h5, s + 8);
    press(4'b0010, 6);

    // Pause at 0101 for well over 64 cycles.
    c = s + 4;
    wait_until(c);
    push(2'd3, 1'b1, 4'h5, s + 12);
    press(4'b0100, 6);

    // Resume: counter was frozen at 4, so the first step lands 4 edges later.
    c = s + 70;
    wait_until(c);
    u = c + 8;
    push(2'd3, 1'b0, 4'h5, u);
    push(2'd3, 1'b0, 4'h6, u + 4);
    push(2'd3, 1'b0, 4'h7, u + 12);
    push(2'd3, 1'b0, 4'h8, u + 20);
    press(4'b0100, 6);

    // Asynchronous reset between edges while COUNT is running.
    wait_until(u + 24);
    check("queue_drained_before_reset", exp_q.size(), 0);
    mon_en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", int'(obs_now()), 0);
    check("async_reset_mode", int'(mode), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Four SW1 presses 14 cycles apart: modes 1,2,3,0, no ticks in between.
    c = cyc + 2;
    for (int i = 0; i < 4; i++) begin
      wait_until(c + 14 * i);
      push(2'(i + 1), 1'b0, (i == 1) ? 4'h1 : 4'h0, c + 14 * i + 8);
      press(4'b0001, 6);
    end
    wait_until(c + 90);
    check("queue_drained_final", exp_q.size(), 0);
    check("final_mode_off", int'(mode), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
